// File: rtl/result_buffer.sv
// result_buffer: packs two successive adder results (lower half, then upper half) into one
// MEM_WORD_SIZE word and queues packed words in a DEPTH-entry FIFO drained by the controller.
// Sticky flags record carry-out (overflow_o) and half-ordering violations (seq_err_o).
// Optional build macro RESULT_BUFFER_CARRY_SAT_EN: a half accepted with carry_i=1 is stored as
// all ones instead of the wrapped sum.
module result_buffer #(
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned MEM_WORD_SIZE = 64,
    parameter int unsigned DEPTH         = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [DATA_W-1:0]          sum_i,
    input  logic                       carry_i,
    input  logic                       sum_valid_i,
    input  logic                       buffer_control_i,
    output logic                       sum_ready_o,
    input  logic                       clear_i,
    output logic [MEM_WORD_SIZE-1:0]   buff_result_o,
    output logic                       word_valid_o,
    input  logic                       word_ready_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o,
    output logic                       seq_err_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic {PEmpty, PLowHeld} pstate_e;

    pstate_e                  pstate_q, pstate_d;
    logic [DATA_W-1:0]        staged_q, staged_d;
    logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]          count_q, count_d;
    logic                     overflow_q, overflow_d;
    logic                     seq_err_q, seq_err_d;
    logic [MEM_WORD_SIZE-1:0] mem_q [DEPTH];

    logic                     accept;
    logic                     push, pop;
    logic                     seq_err_set;
    logic [DATA_W-1:0]        half_data;
    logic [MEM_WORD_SIZE-1:0] push_word;

    assign full_o        = (count_q == CntW'(DEPTH));
    assign empty_o       = (count_q == '0);
    assign count_o       = count_q;
    assign word_valid_o  = ~empty_o;
    assign buff_result_o = word_valid_o ? mem_q[rd_ptr_q] : '0;
    assign overflow_o    = overflow_q;
    assign seq_err_o     = seq_err_q;

    // Lower halves only go to staging, so they never need FIFO room.
    assign sum_ready_o = buffer_control_i ? ~full_o : 1'b1;
    assign accept      = sum_valid_i & sum_ready_o;
    assign pop         = word_valid_o & word_ready_i;

`ifdef RESULT_BUFFER_CARRY_SAT_EN
    assign half_data = carry_i ? {DATA_W{1'b1}} : sum_i;
`else
    assign half_data = sum_i;
`endif

    // Packer: decide staging, pushes and ordering errors for the accepted half.
    always_comb begin
        pstate_d    = pstate_q;
        staged_d    = staged_q;
        push        = 1'b0;
        push_word   = '0;
        seq_err_set = 1'b0;
        if (accept) begin
            unique case (pstate_q)
                PEmpty: begin
                    if (buffer_control_i) begin
                        // Upper with no lower staged: push it with a zero lower half.
                        push        = 1'b1;
                        push_word   = {half_data, {DATA_W{1'b0}}};
                        seq_err_set = 1'b1;
                    end else begin
                        staged_d = half_data;
                        pstate_d = PLowHeld;
                    end
                end
                PLowHeld: begin
                    if (buffer_control_i) begin
                        push      = 1'b1;
                        push_word = {half_data, staged_q};
                        staged_d  = '0;
                        pstate_d  = PEmpty;
                    end else begin
                        // Second lower in a row replaces the staged one.
                        staged_d    = half_data;
                        seq_err_set = 1'b1;
                    end
                end
                default: pstate_d = PEmpty;
            endcase
        end
    end

    // FIFO bookkeeping and sticky flags; clear_i overrides everything else.
    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (accept & carry_i);
        seq_err_d  = seq_err_q | seq_err_set;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
        if (clear_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            seq_err_d  = 1'b0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pstate_q   <= PEmpty;
            staged_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            pstate_q   <= clear_i ? PEmpty : pstate_d;
            staged_q   <= clear_i ? '0 : staged_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            seq_err_q  <= seq_err_d;
        end
    end

    // Storage array; stale entries are masked by word_valid_o so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (push && !clear_i) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

endmodule
